// File: rtl/bp_resolve_queue_pkg.sv
// rtl/bp_resolve_queue_pkg.sv - shared types and helpers for the branch resolve queue
// Entry layout and redirect arithmetic used by both the queue and its buffer.
package bp_resolve_queue_pkg;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        logic      pred;
    } bp_entry_t;

    localparam rv32i_word BP_PC_INC = 32'd4;

    // Correct next PC once the real direction is known; fall-through wraps at 2^32.
    function automatic rv32i_word bp_redirect_pc(input bp_entry_t entry,
                                                 input logic      taken,
                                                 input rv32i_word target);
        return taken ? target : entry.pc + BP_PC_INC;
    endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// rtl/bp_resolve_queue_if.sv - fetch/execute/predictor signal bundle for the resolve queue
// The pipeline side is the master; the queue itself is the slave.
interface bp_resolve_queue_if
    import bp_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 32
);

    logic                     stall;
    logic                     push;
    rv32i_word                push_pc;
    logic                     push_pred;
    logic                     resolve;
    logic                     resolve_taken;
    rv32i_word                resolve_target;

    logic                     upd_en;
    rv32i_word                upd_addr;
    logic                     upd_taken;
    logic                     mispredict;
    rv32i_word                redirect_pc;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;
    logic [CW-1:0]            correct_cnt;
    logic [CW-1:0]            mispred_cnt;

    modport master (
        output stall, push, push_pc, push_pred, resolve, resolve_taken, resolve_target,
        input  upd_en, upd_addr, upd_taken, mispredict, redirect_pc,
        input  count, full, empty, overflow, underflow, correct_cnt, mispred_cnt
    );

    modport slave (
        input  stall, push, push_pc, push_pred, resolve, resolve_taken, resolve_target,
        output upd_en, upd_addr, upd_taken, mispredict, redirect_pc,
        output count, full, empty, overflow, underflow, correct_cnt, mispred_cnt
    );

endinterface

// File: rtl/bp_resolve_queue_fifo.sv
// rtl/bp_resolve_queue_fifo.sv - DEPTH-entry circular buffer of in-flight predictions
// Flush collapses head onto tail and outranks any push or pop in the same cycle.
module bp_resolve_queue_fifo
    import bp_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  bp_entry_t              i_wdata,
    output bp_entry_t              o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    bp_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;

    logic            w_do_pop;
    logic            w_do_push;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_head];

    // A pop frees the slot a simultaneous push needs when the buffer is full.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// rtl/bp_resolve_queue.sv - matches fetch predictions to execute outcomes
// Drives predictor training, mispredict redirect, error pulses and accuracy counters.
module bp_resolve_queue
    import bp_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    bp_resolve_queue_if.slave    bus
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    bp_entry_t         w_head;
    bp_entry_t         w_push_entry;
    logic [CNTW-1:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_eff_resolve;
    logic              w_flush_now;
    logic              w_eff_push;
    logic              w_overflow_now;
    logic              w_underflow_now;

    logic              r_upd_en;
    rv32i_word         r_upd_addr;
    logic              r_upd_taken;
    logic              r_mispredict;
    rv32i_word         r_redirect_pc;
    logic              r_overflow;
    logic              r_underflow;
    logic [CW-1:0]     r_correct_cnt;
    logic [CW-1:0]     r_mispred_cnt;

    assign w_push_entry    = '{pc: bus.push_pc, pred: bus.push_pred};

    assign w_eff_resolve   = bus.resolve & ~bus.stall & ~w_empty;
    assign w_flush_now     = w_eff_resolve & (w_head.pred != bus.resolve_taken);
    // A push in the mispredicting cycle is younger than the bad branch, so it dies too.
    assign w_eff_push      = bus.push & ~bus.stall & (~w_full | w_eff_resolve) & ~w_flush_now;
    assign w_overflow_now  = bus.push & ~bus.stall & w_full & ~w_eff_resolve;
    assign w_underflow_now = bus.resolve & ~bus.stall & w_empty;

    bp_resolve_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_eff_push),
        .i_pop   (w_eff_resolve),
        .i_flush (w_flush_now),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_en      <= 1'b0;
            r_upd_addr    <= '0;
            r_upd_taken   <= 1'b0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_upd_en      <= w_eff_resolve;
            r_upd_addr    <= w_eff_resolve ? w_head.pc : '0;
            r_upd_taken   <= w_eff_resolve & bus.resolve_taken;
            r_mispredict  <= w_flush_now;
            r_redirect_pc <= w_eff_resolve ?
                             bp_redirect_pc(w_head, bus.resolve_taken, bus.resolve_target) : '0;
            r_overflow    <= w_overflow_now;
            r_underflow   <= w_underflow_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_correct_cnt <= '0;
            r_mispred_cnt <= '0;
        end else if (w_eff_resolve) begin
            if (w_flush_now) begin
                r_mispred_cnt <= r_mispred_cnt + CW'(1);
            end else begin
                r_correct_cnt <= r_correct_cnt + CW'(1);
            end
        end
    end

    assign bus.upd_en      = r_upd_en;
    assign bus.upd_addr    = r_upd_addr;
    assign bus.upd_taken   = r_upd_taken;
    assign bus.mispredict  = r_mispredict;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.count       = w_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.correct_cnt = r_correct_cnt;
    assign bus.mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb/tb_bp_resolve_queue.sv - directed and random checks of bp_resolve_queue against a queue model
module tb_bp_resolve_queue;
    import bp_resolve_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bp_resolve_queue_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    bp_resolve_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;

    bp_entry_t   m_q[$];
    logic        m_upd_en, m_upd_taken, m_mis, m_ovf, m_unf;
    logic [31:0] m_upd_addr, m_redir;
    logic [CW-1:0] m_ok, m_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // One clock: drive inputs, predict next-cycle outputs, then compare after the edge.
    task automatic cyc(input logic r, input logic s, input logic p, input logic [31:0] pc,
                       input logic pd, input logic rv, input logic tk, input logic [31:0] tg);
        logic er, mis, ok_push;
        rst                = r;
        bus.stall          = s;
        bus.push           = p;
        bus.push_pc        = pc;
        bus.push_pred      = pd;
        bus.resolve        = rv;
        bus.resolve_taken  = tk;
        bus.resolve_target = tg;
        if (r) begin
            m_q.delete();
            {m_upd_en, m_upd_taken, m_mis, m_ovf, m_unf} = '0;
            m_upd_addr = '0;
            m_redir    = '0;
            m_ok       = '0;
            m_bad      = '0;
        end else begin
            er      = rv && !s && (m_q.size() > 0);
            mis     = er && (m_q[0].pred != tk);
            ok_push = p && !s && ((m_q.size() < DEPTH) || er) && !mis;
            m_ovf   = p && !s && (m_q.size() == DEPTH) && !er;
            m_unf   = rv && !s && (m_q.size() == 0);
            m_upd_en    = er;
            m_upd_addr  = er ? m_q[0].pc : 32'h0;
            m_upd_taken = er && tk;
            m_mis       = mis;
            m_redir     = er ? (tk ? tg : m_q[0].pc + 32'd4) : 32'h0;
            if (er) begin
                if (mis) m_bad++;
                else     m_ok++;
                void'(m_q.pop_front());
            end
            if (mis) m_q.delete();
            if (ok_push) m_q.push_back('{pc: pc, pred: pd});
        end
        @(posedge clk);
        #1;
        chk("upd_en",      bus.upd_en,      m_upd_en);
        chk("upd_addr",    bus.upd_addr,    m_upd_addr);
        chk("upd_taken",   bus.upd_taken,   m_upd_taken);
        chk("mispredict",  bus.mispredict,  m_mis);
        chk("redirect_pc", bus.redirect_pc, m_redir);
        chk("count",       bus.count,       m_q.size());
        chk("full",        bus.full,        m_q.size() == DEPTH);
        chk("empty",       bus.empty,       m_q.size() == 0);
        chk("overflow",    bus.overflow,    m_ovf);
        chk("underflow",   bus.underflow,   m_unf);
        chk("correct_cnt", bus.correct_cnt, m_ok);
        chk("mispred_cnt", bus.mispred_cnt, m_bad);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pd);
        cyc(1'b0, 1'b0, 1'b1, pc, pd, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_resolve(input logic tk, input logic [31:0] tg);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, tk, tg);
    endtask

    initial begin
        logic        s, p, pd, rv, tk, r;
        logic [31:0] pc, tg;

        // Reset held two cycles
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Correct prediction
        do_push(32'h60, 1'b1);
        do_resolve(1'b1, 32'h80);
        idle();

        // Mispredict flush with a same-cycle push that must be dropped
        do_push(32'h10, 1'b1);
        do_push(32'h20, 1'b1);
        do_push(32'h30, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h999);
        do_resolve(1'b1, 32'h0);

        // Full boundary: overflow, then push+resolve while full, then drain
        for (int i = 0; i < 4; i++) do_push(32'h200 + 32'(i * 4), 1'b0);
        do_push(32'h300, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h304, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) do_resolve(1'b0, 32'h0);

        // Empty resolve and simultaneous push+resolve on empty
        do_resolve(1'b1, 32'h44);
        cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 32'h0);
        do_resolve(1'b1, 32'h600);

        // Fall-through redirect wraps past 2^32
        do_push(32'hFFFF_FFFC, 1'b1);
        do_resolve(1'b0, 32'h0);

        // Stall toggling over push/resolve pairs, pointers wrap
        for (int i = 0; i < 10; i++) begin
            s = i[0];
            cyc(1'b0, s, 1'b1, 32'h1000 + 32'(i * 8), 1'b1, 1'b0, 1'b0, 32'h0);
            cyc(1'b0, ~s, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2000 + 32'(i));
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3000 + 32'(i));
        end

        // Mid-operation reset suppresses pending pulses
        do_push(32'h70, 1'b0);
        do_push(32'h74, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 2) != 0);
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            pd = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 1) == 1);
            tg = $urandom() & 32'hFFFF_FFFC;
            if (m_q.size() > 0 && $urandom_range(0, 4) != 0) tk = m_q[0].pred;
            else tk = 1'($urandom_range(0, 1));
            cyc(r, s, p, pc, pd, rv, tk, tg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_resolve_queue.md
# bp_resolve_queue

Resolution-side companion to the fetch-stage 2-bit local branch predictor. It records every prediction issued at fetch in an in-order FIFO and matches it against the branch outcome resolved in execute. It then drives the predictor's training write port (address, actual outcome, write enable) and produces the mispredict redirect for the fetch PC mux. It also keeps correct/mispredict statistics counters for performance analysis.

## Interface
- DEPTH, 4, in-flight branch entries; power of two, ≥2
- CW, 32, statistics counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  pipeline stall; when high, push and resolve are ignored
- push  in  1  fetch issued a predicted conditional branch this cycle
- push_pc  in  32  PC of that branch
- push_pred  in  1  predicted direction (predictor MSB), 1 = taken
- resolve  in  1  execute resolved the oldest in-flight branch
- resolve_taken  in  1  actual direction
- resolve_target  in  32  computed taken target
- upd_en  out  1  training write enable to predictor (one-cycle pulse)
- upd_addr  out  32  PC to train (predictor indexes [7:2])
- upd_taken  out  1  actual outcome for saturating-counter update
- mispredict  out  1  one-cycle pulse: flush younger instructions
- redirect_pc  out  32  correct next PC, valid when mispredict=1
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  count==DEPTH, count==0
- overflow, underflow  out  1  one-cycle error pulses
- correct_cnt, mispred_cnt  out  CW  statistics

## Operation
- Circular buffer: entry = {pc, pred}; head = oldest, tail = next write; pointers wrap modulo DEPTH.
- Effective push: push & ~stall & (~full | eff_resolve) & ~flush_now. Effective resolve: resolve & ~stall & ~empty.
- On effective resolve, head entry is popped. The registered outputs are then set for the next cycle:
  - upd_en=1, upd_addr=head.pc, upd_taken=resolve_taken.
  - mispredict = (head.pred != resolve_taken).
  - redirect_pc = resolve_target if resolve_taken, else head.pc+4 (32-bit wrap).
- Mispredict flush: in the cycle after a mispredicting resolve, head=tail and count=0. A push presented in the resolve cycle itself is dropped (flush_now is the combinational mismatch).
- Simultaneous push and resolve:
  - When full, the push is accepted and count is unchanged.
  - When empty, the resolve sees an empty queue: underflow pulses and the push is accepted.
- Push while full without a resolve: entry dropped, overflow pulses next cycle.
- Resolve while empty: nothing popped, no upd_en, underflow pulses next cycle.
- Statistics: correct_cnt increments on a matching resolve, mispred_cnt on a mismatch; both wrap modulo 2^CW.
- Reset: all outputs 0, empty=1, count=0, pointers 0, counters 0. Reset mid-operation discards all entries and suppresses any pending pulse.

## Timing
- Push at edge N: the entry is visible (count incremented) after edge N; the earliest resolve of that entry is cycle N+1.
- Resolve sampled at edge N: upd_*, mispredict, redirect_pc are valid in cycle N+1 for exactly one cycle, then return to 0.
- Predictor write lands at edge N+2 (its own registered write).
- Back-to-back resolves are supported: one per cycle.
- Resolve in cycle N+1 after a mispredict sees an empty queue and underflows. The pipeline must squash it; it is counted as an error, not trained.
- stall freezes pointers and count. Pulses already in flight still complete.

## Structure
- Shared package (the control types package): typedef bp_entry_t {rv32i_word pc; logic pred;}; constant BP_PC_INC = 4.
- Sub-module bp_fifo: generic DEPTH×bp_entry_t circular buffer with push/pop/flush and count/full/empty.
- Top level: accept logic, compare, registered update/redirect outputs, and statistics counters.

## Test plan
- Reset: assert rst 2 cycles -> all outputs 0, empty=1, count=0, counters 0.
- Correct prediction:
  - Stimulus: push pc=0x60 pred=1; next cycle resolve taken=1, target=0x80.
  - Required: next cycle upd_en=1, upd_addr=0x60, upd_taken=1, mispredict=0, correct_cnt=1.
- Mispredict flush:
  - Stimulus: push 0x10 (pred 1), 0x20, 0x30; resolve head with taken=0.
  - Required: next cycle mispredict=1, redirect_pc=0x14, count=0, mispred_cnt=1. A push in the resolve cycle is dropped.
- Full boundary (DEPTH=4):
  - Stimulus: 4 pushes, then a 5th push alone.
  - Required: overflow pulse, count=4.
  - Stimulus: push and resolve in the same cycle.
  - Required: count stays 4, tail wraps to 1.
- Empty resolve:
  - Stimulus: resolve with count=0.
  - Required: underflow=1, upd_en=0, counters unchanged.
- Stall and wrap:
  - Stimulus: 10 push/resolve pairs with stall toggling.
  - Required: no state change during stall; pointers wrap and every upd_addr matches its pushed PC in order.
